regbank_onehot: RTL and testbench



---
 rtl/regbank_onehot_if.sv | 45 ++++
 rtl/regbank_onehot.sv | 88 ++++++++
 tb/tb_regbank_onehot.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regbank_onehot_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : regbank_onehot_if                                        |
// | Description : Write/read/error bus of the one-hot register bank.       |
// |               master = control/decoder side, slave = register bank.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface regbank_onehot_if #(
   parameter int WIDTH = 16
);
   logic             wr_en;
   logic [15:0]      wr_sel;
   logic [WIDTH-1:0] wr_data;
   logic [3:0]       rd_addr_a;
   logic [3:0]       rd_addr_b;
   logic [WIDTH-1:0] rd_data_a;
   logic [WIDTH-1:0] rd_data_b;
   logic             err_clr;
   logic             sel_err;

   modport master (
      output wr_en,
      output wr_sel,
      output wr_data,
      output rd_addr_a,
      output rd_addr_b,
      output err_clr,
      input  rd_data_a,
      input  rd_data_b,
      input  sel_err
   );

   modport slave (
      input  wr_en,
      input  wr_sel,
      input  wr_data,
      input  rd_addr_a,
      input  rd_addr_b,
      input  err_clr,
      output rd_data_a,
      output rd_data_b,
      output sel_err
   );
endinterface
`default_nettype wire

// File: rtl/regbank_onehot.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : regbank_onehot                                           |
// | Description : 16 x WIDTH register bank written through a one-hot       |
// |               select, two registered read ports, sticky error flag     |
// |               for non-one-hot write selects.                           |
// |               Macro REGBANK_BYPASS_EN: when defined, a read of the     |
// |               register being written returns the new data; otherwise   |
// |               it returns the old contents.                             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module regbank_onehot #(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   regbank_onehot_if.slave   bus
);
   localparam int c_num_regs = 16;

   logic [WIDTH-1:0] r_regs [c_num_regs];
   logic [WIDTH-1:0] r_rd_data_a;
   logic [WIDTH-1:0] r_rd_data_b;
   logic             r_sel_err;

   logic             w_sel_onehot;
   logic             w_wr_valid;
   logic             w_wr_bad;
   logic             w_fwd_a;
   logic             w_fwd_b;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign w_sel_onehot = (bus.wr_sel != 16'h0000) &&
                         ((bus.wr_sel & (bus.wr_sel - 16'd1)) == 16'h0000);
   assign w_wr_valid   = bus.wr_en &  w_sel_onehot;
   assign w_wr_bad     = bus.wr_en & ~w_sel_onehot;

`ifdef REGBANK_BYPASS_EN
   // Forward only genuine writes; a malformed select never forwards.
   assign w_fwd_a = w_wr_valid & bus.wr_sel[bus.rd_addr_a];
   assign w_fwd_b = w_wr_valid & bus.wr_sel[bus.rd_addr_b];
`else
   assign w_fwd_a = 1'b0;
   assign w_fwd_b = 1'b0;
`endif

   // Register array: cleared on reset, otherwise updated by a qualified write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < c_num_regs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_valid) begin
         for (int i = 0; i < c_num_regs; i++) begin
            if (bus.wr_sel[i]) begin
               r_regs[i] <= bus.wr_data;
            end
         end
      end
   end

   // Registered read ports, with optional same-cycle write forwarding.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data_a <= '0;
         r_rd_data_b <= '0;
      end else begin
         r_rd_data_a <= w_fwd_a ? bus.wr_data : r_regs[bus.rd_addr_a];
         r_rd_data_b <= w_fwd_b ? bus.wr_data : r_regs[bus.rd_addr_b];
      end
   end

   // Sticky select error: reset wins, then a new error, then the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel_err <= 1'b0;
      end else if (w_wr_bad) begin
         r_sel_err <= 1'b1;
      end else if (bus.err_clr) begin
         r_sel_err <= 1'b0;
      end
   end

   assign bus.rd_data_a = r_rd_data_a;
   assign bus.rd_data_b = r_rd_data_b;
   assign bus.sel_err   = r_sel_err;
endmodule
`default_nettype wire

// File: tb/tb_regbank_onehot.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_regbank_onehot                                        |
// | Description : Directed scoreboard bench for regbank_onehot. Each       |
// |               stimulus cycle queues the values expected after its      |
// |               clock edge; a monitor pops and compares after each edge. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_regbank_onehot;
   logic clk;
   logic reset;

   regbank_onehot_if #(.WIDTH(16)) bus ();

   regbank_onehot #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ca;
      logic [15:0] ea;
      logic        cb;
      logic [15:0] eb;
      logic        ce;
      logic        ee;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

`ifdef REGBANK_BYPASS_EN
   localparam logic [15:0] c_rdw_exp = 16'h5678;
`else
   localparam logic [15:0] c_rdw_exp = 16'h1234;
`endif

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // One stimulus cycle: drive inputs, queue the post-edge expectation.
   task automatic step(input logic rst, input logic en, input logic [15:0] sel,
                       input logic [15:0] data, input logic [3:0] ra, input logic [3:0] rb,
                       input logic clr,
                       input logic ca, input logic [15:0] ea,
                       input logic cb, input logic [15:0] eb,
                       input logic ce, input logic ee, input string nm);
      exp_t e;
      reset          = rst;
      bus.wr_en      = en;
      bus.wr_sel     = sel;
      bus.wr_data    = data;
      bus.rd_addr_a  = ra;
      bus.rd_addr_b  = rb;
      bus.err_clr    = clr;
      e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb; e.ce = ce; e.ee = ee; e.nm = nm;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expectation per clock edge, compared after outputs settle.
   initial begin
      exp_t m;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            m = q.pop_front();
            if (m.ca) chk({m.nm, ".rd_data_a"}, bus.rd_data_a, m.ea);
            if (m.cb) chk({m.nm, ".rd_data_b"}, bus.rd_data_b, m.eb);
            if (m.ce) chk({m.nm, ".sel_err"}, {15'd0, bus.sel_err}, {15'd0, m.ee});
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] sel;
      logic [15:0] val_a;
      logic [15:0] val_b;

      // Reset, then sweep both ports over all entries.
      step(1, 0, 16'h0, 16'h0, 4'd0, 4'd0, 0, 1, 16'h0, 1, 16'h0, 1, 0, "reset");
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 16'h0, 16'h0, 4'(i), 4'(15 - i), 0,
              1, 16'h0, 1, 16'h0, 1, 0, "rst_sweep");
      end

      // Write R3 and read it back next to an untouched neighbour.
      step(0, 1, 16'h0008, 16'hA5A5, 4'd0, 4'd0, 0, 1, 16'h0, 1, 16'h0, 1, 0, "wr_r3");
      step(0, 0, 16'h0, 16'h0, 4'd3, 4'd4, 0, 1, 16'hA5A5, 1, 16'h0, 1, 0, "rd_r3_r4");

      // Malformed selects and error flag handling.
      step(0, 1, 16'h0011, 16'hFFFF, 4'd0, 4'd4, 0, 1, 16'h0, 1, 16'h0, 1, 1, "bad_sel_2bit");
      step(0, 0, 16'h0, 16'h0, 4'd0, 4'd4, 1, 1, 16'h0, 1, 16'h0, 1, 0, "clr_err");
      step(0, 1, 16'h0000, 16'h5555, 4'd3, 4'd3, 0, 1, 16'hA5A5, 1, 16'hA5A5, 1, 1, "bad_sel_zero");
      step(0, 1, 16'h0011, 16'hFFFF, 4'd3, 4'd0, 1, 1, 16'hA5A5, 1, 16'h0, 1, 1, "set_over_clr");
      step(0, 0, 16'h0, 16'h0, 4'd0, 4'd0, 1, 1, 16'h0, 1, 16'h0, 1, 0, "clr_only");
      step(0, 0, 16'h00FF, 16'hFFFF, 4'd0, 4'd4, 0, 1, 16'h0, 1, 16'h0, 1, 0, "en_low_ignored");

      // Read-during-write on R7.
      step(0, 1, 16'h0080, 16'h1234, 4'd0, 4'd4, 0, 1, 16'h0, 1, 16'h0, 1, 0, "wr_r7");
      step(0, 1, 16'h0080, 16'h5678, 4'd7, 4'd7, 0, 1, c_rdw_exp, 1, c_rdw_exp, 1, 0, "rdw_r7");
      step(0, 0, 16'h0, 16'h0, 4'd7, 4'd3, 0, 1, 16'h5678, 1, 16'hA5A5, 1, 0, "rd_r7_after");

      // Reset priority over a valid write and a set error flag.
      step(0, 1, 16'h0003, 16'h0, 4'd7, 4'd3, 0, 1, 16'h5678, 1, 16'hA5A5, 1, 1, "bad_before_rst");
      step(1, 1, 16'h8000, 16'hBEEF, 4'd15, 4'd3, 0, 1, 16'h0, 1, 16'h0, 1, 0, "rst_priority");
      step(0, 0, 16'h0, 16'h0, 4'd15, 4'd3, 0, 1, 16'h0, 1, 16'h0, 1, 0, "rd_after_rst");

      // Back-to-back writes to every entry, then a full readback.
      for (int n = 0; n < 16; n++) begin
         sel = 16'h0001 << n;
         step(0, 1, sel, 16'h0100 + 16'(n), 4'd15, 4'd15, 0,
              0, 16'h0, 0, 16'h0, 1, 0, "b2b_wr");
      end
      for (int n = 0; n < 16; n++) begin
         val_a = 16'h0100 + 16'(n);
         val_b = 16'h0100 + 16'(15 - n);
         step(0, 0, 16'h0, 16'h0, 4'(n), 4'(15 - n), 0,
              1, val_a, 1, val_b, 1, 0, "b2b_rd");
      end

      repeat (3) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
